// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - shared FSM state and ALU opcode definitions
// Contents: state_t (IDLE/EXEC/RESP) and the OP_* opcode constants used by
// the arbiter and its ALU datapath.
package alu_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_AND  = 4'd9;
    localparam logic [3:0] OP_MAX  = 4'd9;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - purely combinational ALU shared by both requesters
// Ports:
//   sel     in   opcode (0..9 legal, 10..15 illegal)
//   a, b    in   operands, WIDTH bits
//   result  out  operation result, 0 for illegal opcodes
//   a_zero  out  operand a is zero
//   illegal out  opcode is outside 0..OP_MAX
module alu_core
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             a_zero,
    output logic             illegal
);

    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0] shamt;

    assign shamt  = b[SHW-1:0];
    assign a_zero = (a == '0);

    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (sel)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_SLL:  result = a << shamt;
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: result = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_XOR:  result = a ^ b;
            OP_SRL:  result = a >> shamt;
            OP_SRA:  result = $signed(a) >>> shamt;
            OP_OR:   result = a | b;
            OP_AND:  result = a & b;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one ALU between two requesters
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   reqN_valid/ready         request handshake for requester N (N=0,1)
//   reqN_sel, reqN_a/b       opcode and operands
//   respN_valid/ready        response handshake for requester N
//   respN_data/zero/err      result, a==0 flag, illegal-opcode flag
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_sel,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_sel,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic [WIDTH-1:0] resp0_data,
    output logic             resp0_zero,
    output logic             resp0_err,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp1_data,
    output logic             resp1_zero,
    output logic             resp1_err
);

    state_t           state_q;
    state_t           state_d;
    logic             owner_q;
    logic             last_q;
    logic [3:0]       sel_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] data_q;
    logic             zero_q;
    logic             err_q;

    logic             grant1;
    logic             accept;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic             alu_illegal;

    // Requester 1 wins when it is alone, or on a tie when requester 0 was
    // granted last.
    assign grant1 = req1_valid & (~req0_valid | ~last_q);
    assign accept = req0_ready | req1_ready;

    alu_core #(.WIDTH(WIDTH)) u_alu_core (
        .sel     (sel_q),
        .a       (a_q),
        .b       (b_q),
        .result  (alu_result),
        .a_zero  (alu_zero),
        .illegal (alu_illegal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Readies are gated by rst so that they drop the moment reset asserts,
    // not only once the state register has been cleared.
    always_comb begin
        state_d     = state_q;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        resp0_valid = 1'b0;
        resp1_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rst) begin
                    req0_ready = req0_valid & ~grant1;
                    req1_ready = grant1;
                    if (req0_valid | req1_valid) begin
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                resp0_valid = ~owner_q;
                resp1_valid = owner_q;
                if (owner_q ? resp1_ready : resp0_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            sel_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                owner_q <= req1_ready;
                last_q  <= req1_ready;
                sel_q   <= req1_ready ? req1_sel : req0_sel;
                a_q     <= req1_ready ? req1_a   : req0_a;
                b_q     <= req1_ready ? req1_b   : req0_b;
            end
            if (state_q == ST_EXEC) begin
                data_q <= alu_result;
                zero_q <= alu_zero;
                err_q  <= alu_illegal;
            end
        end
    end

    // The result registers only change in EXEC, so they are stable for the
    // whole RESP phase; both ports see them and only the owner's valid rises.
    assign resp0_data = data_q;
    assign resp0_zero = zero_q;
    assign resp0_err  = err_q;
    assign resp1_data = data_q;
    assign resp1_zero = zero_q;
    assign resp1_err  = err_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 reqN_valid  input  1  requester N (N=0,1) presents an operation.
REQ-005 reqN_ready  output  1  arbiter accepts requester N's operation this cycle.
REQ-006 reqN_sel  input  4  ALU operation code, 0..9; same encoding as the shared ALU.
REQ-007 reqN_a, reqN_b  input  WIDTH  operands.
REQ-008 respN_valid  output  1  result for requester N is available.
REQ-009 respN_ready  input  1  requester N consumes its result.
REQ-010 respN_data  output  WIDTH  result value.
REQ-011 respN_zero  output  1  operand a of the completed operation was zero.
REQ-012 respN_err  output  1  the completed operation carried an illegal sel (10..15).

Function
REQ-013 The block SHALL share one ALU instance between the two requesters and SHALL keep at most one operation in flight.
REQ-014 FSM states SHALL be IDLE, EXEC and RESP; reset state SHALL be IDLE.
REQ-015 In IDLE, reqN_ready SHALL be asserted combinationally only for the granted requester, and only while that requester's valid is high; in EXEC and RESP both readies SHALL be 0.
REQ-016 Grant SHALL be round-robin: with a single valid, grant that one; with both valid, grant the requester not granted last; the last-grant pointer SHALL reset to 1, so requester 0 wins the first tie.
REQ-017 On accept (valid & ready), sel, a, b and the owner id SHALL be registered and the FSM SHALL go IDLE->EXEC.
REQ-018 In EXEC, the registered operands SHALL drive the ALU; its output, zero flag and the err flag SHALL be registered; the FSM SHALL go EXEC->RESP.
REQ-019 In RESP, respN_valid SHALL be 1 for the owner only, with data/zero/err stable, until respN_ready; on that handshake the FSM SHALL return to IDLE.
REQ-020 Latency: accept in cycle T SHALL yield respN_valid in cycle T+2; the next accept SHALL occur no earlier than the cycle after the response handshake.
REQ-021 Holding respN_ready high early SHALL complete the response in its first valid cycle; deasserting reqN_valid after accept SHALL have no effect.
REQ-022 Illegal sel SHALL produce respN_data = 0 and respN_err = 1; legal sel SHALL produce respN_err = 0.
REQ-023 ALU results SHALL be: 0 add, 1 sub (both modulo 2^WIDTH), 2 sll, 3 slt signed, 4 sltu, 5 xor, 6 srl, 7 sra (arithmetic, sign of a), 8 or, 9 and; shift amount SHALL be b[log2(WIDTH)-1:0].
REQ-024 respN_zero SHALL equal (a == 0) for the operation's registered a.

Reset
REQ-025 Assertion of rst SHALL immediately force IDLE, both readies and both resp valids to 0, data to 0, zero and err to 0, and the pointer to 1.
REQ-026 rst during EXEC or RESP SHALL discard the in-flight operation without any response.

Structure
REQ-027 A shared package SHALL hold the FSM state enumeration and the ALU opcode constants (ADD=0 .. AND=9, OP_MAX=9).
REQ-028 The datapath SHALL be one sub-module instance, alu_core, with 3-bit-wider-free interface: sel, a, b in; result, a_zero, illegal out; purely combinational.

Verification
REQ-029 req0 only, sel=0, a=5, b=7, resp0_ready=1 -> resp0_valid two cycles after accept, data=12, zero=0, err=0.
REQ-030 Both valid in the same cycle after reset, sel=1, a=3, b=5 for req0 -> req0 granted first, data=0xFFFFFFFE; req1 granted next, then req0 again if both still valid.
REQ-031 req1 sel=7, a=0x80000000, b=4, resp1_ready low for 3 cycles -> resp1_valid held, data=0xF8000000 stable, no new accept until handshake.
REQ-032 req0 sel=12, a=0, b=1 -> data=0, err=1, zero=1.
REQ-033 rst asserted while in EXEC -> both resp valids 0 immediately, FSM IDLE, no response after rst release.
REQ-034 sel=3, a=0xFFFFFFFF, b=1 -> data=1; sel=4 with same operands -> data=0.
